// File: rtl/cpu_clk_pkg.sv
// rtl/cpu_clk_pkg.sv - shared defaults, state encoding and widths for the clock/reset generator
package cpu_clk_pkg;

  localparam int DIV_DEFAULT         = 4;
  localparam int HOLD_CYCLES_DEFAULT = 8;
  localparam int CYCLE_COUNT_W       = 32;

  localparam logic [1:0] ST_RST  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

endpackage

// File: rtl/rst_stretch.sv
// rtl/rst_stretch.sv - counts slow rising edges and releases core_reset on the following slow falling edge
module rst_stretch
  import cpu_clk_pkg::*;
#(
  parameter int DIV         = DIV_DEFAULT,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic slow_rise,
  output logic core_reset,
  output logic done
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam int DW = (DIV > 2) ? $clog2(DIV / 2) : 1;

  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_dly;
  logic          r_core_reset;
  logic          w_counted;

  assign w_counted = (r_cnt == CW'(HOLD_CYCLES));

  // A frozen clock can only park on the falling edge itself, so the fall is
  // always exactly DIV/2 fast edges after the last counted rise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_dly        <= '0;
      r_core_reset <= 1'b1;
    end else begin
      if (slow_rise && !w_counted) r_cnt <= r_cnt + CW'(1);
      if (w_counted && r_core_reset) begin
        if (r_dly == DW'(DIV / 2 - 1)) r_core_reset <= 1'b0;
        else                           r_dly        <= r_dly + DW'(1);
      end
    end
  end

  assign core_reset = r_core_reset;
  assign done       = w_counted;

endmodule

// File: rtl/clock_reset_gen.sv
// rtl/clock_reset_gen.sv - slow core clock divider with freeze, stretched core reset and RUN cycle counter
module clock_reset_gen
  import cpu_clk_pkg::*;
#(
  parameter int DIV         = DIV_DEFAULT,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clk_hold,
  output logic                     imem_clock,
  output logic                     dmem_clock,
  output logic                     processor_clock,
  output logic                     regfile_clock,
  output logic                     core_reset,
  output logic                     clocks_ready,
  output logic [CYCLE_COUNT_W-1:0] cycle_count
);

  localparam int             PW      = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PH_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0]  PH_HALF = PW'(DIV / 2);
  localparam logic [PW-1:0]  PH_PRE  = PW'(DIV / 2 - 1);

  logic [PW-1:0]            r_ph;
  logic                     r_pclk;
  logic [1:0]               r_state;
  logic [CYCLE_COUNT_W-1:0] r_cycle_count;
  logic [PW-1:0]            w_ph_next;
  logic                     w_freeze;
  logic                     w_slow_rise;
  logic                     w_slow_fall;
  logic                     w_done;

  // Freezing only at the start of the low phase keeps every high pulse full width.
  assign w_freeze    = clk_hold && (r_ph == PH_HALF);
  assign w_slow_rise = (r_ph == PH_LAST) && !w_freeze;
  assign w_slow_fall = (r_ph == PH_PRE);

  always_comb begin
    w_ph_next = r_ph + PW'(1);
    if (w_freeze)              w_ph_next = r_ph;
    else if (r_ph == PH_LAST)  w_ph_next = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ph          <= '0;
      r_pclk        <= 1'b0;
      r_state       <= ST_RST;
      r_cycle_count <= '0;
    end else begin
      r_ph <= w_ph_next;
      if (w_slow_rise)      r_pclk <= 1'b1;
      else if (w_slow_fall) r_pclk <= 1'b0;
      case (r_state)
        ST_RST:  r_state <= ST_HOLD;
        ST_HOLD: if (w_done && w_slow_fall) r_state <= ST_RUN;
        default: ;
      endcase
      if (r_state == ST_RUN && w_slow_rise) r_cycle_count <= r_cycle_count + CYCLE_COUNT_W'(1);
    end
  end

  rst_stretch #(
    .DIV         (DIV),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_rst_stretch (
    .clock      (clock),
    .reset      (reset),
    .slow_rise  (w_slow_rise),
    .core_reset (core_reset),
    .done       (w_done)
  );

  assign imem_clock      = ~clock;
  assign dmem_clock      = ~clock;
  assign processor_clock = r_pclk;
  assign regfile_clock   = r_pclk;
  assign clocks_ready    = (r_state == ST_RUN);
  assign cycle_count     = r_cycle_count;

endmodule

// File: doc/clock_reset_gen.md
CLOCK_RESET_GEN -- requirements
Module: clock_reset_gen

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning the fast-to-slow clock ratio; it must be even and at least 2.
REQ-002 SHALL have parameter HOLD_CYCLES, default 8, meaning the number of slow cycles that core_reset stays asserted after reset release.
REQ-003 SHALL have port clock, input, 1 bit: the single system clock. All registers update on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port clk_hold, input, 1 bit: request to freeze the slow clocks. Sampled on the rising edge of clock.
REQ-006 SHALL have port imem_clock, output, 1 bit: instruction-memory clock, equal to ~clock.
REQ-007 SHALL have port dmem_clock, output, 1 bit: data-memory clock, equal to ~clock.
REQ-008 SHALL have port processor_clock, output, 1 bit: slow core clock, driven directly from a register.
REQ-009 SHALL have port regfile_clock, output, 1 bit: always identical to processor_clock.
REQ-010 SHALL have port core_reset, output, 1 bit: stretched reset for the processor and regfile, driven from a register.
REQ-011 SHALL have port clocks_ready, output, 1 bit: high while the state is RUN.
REQ-012 SHALL have port cycle_count, output, 32 bits: number of slow rising edges seen in RUN.

Function
REQ-013 SHALL keep a phase counter ph that runs 0..DIV-1, increments on each clock edge, and wraps from DIV-1 back to 0.
REQ-014 SHALL register processor_clock high for ph in [0, DIV/2) and low for ph in [DIV/2, DIV), giving a 50% duty cycle.
REQ-015 SHALL have a slow rising edge occur exactly when ph goes from DIV-1 to 0; with DIV=4 the period is 4 clock periods.
REQ-016 SHALL implement a state machine with states RST, HOLD and RUN:
- RST: entered on reset; leaves to HOLD on the first clock edge after reset is released.
- HOLD: counts slow rising edges; moves to RUN on the falling edge of processor_clock (ph becoming DIV/2) once HOLD_CYCLES rising edges have been counted.
- RUN: terminal state until the next reset.
REQ-017 SHALL hold core_reset at 1 in RST and HOLD, and drop it to 0 on the same edge that enters RUN. It therefore always changes while processor_clock is low.
REQ-018 SHALL increment cycle_count by 1 on each slow rising edge in RUN, wrapping from 0xFFFFFFFF to 0.
REQ-019 SHALL, when clk_hold=1, finish the current high phase, then keep processor_clock at 0 and freeze ph at DIV/2.
REQ-020 SHALL resume counting from ph=DIV/2 on the first edge with clk_hold=0, so no runt pulse is produced.
REQ-021 SHALL treat clk_hold asserted in RST or HOLD as freezing the HOLD count too; stretched reset time is measured in real slow edges.
REQ-022 SHALL NOT increment cycle_count while the clock is frozen.
REQ-023 SHALL NOT let a clk_hold assertion or release change the width of any high pulse of processor_clock.
REQ-024 SHALL allow no combinational path except the imem_clock and dmem_clock inversions.

Reset
REQ-025 SHALL, while reset=1 (taking effect immediately), hold these values: ph=0, processor_clock=0, regfile_clock=0, core_reset=1, clocks_ready=0, cycle_count=0, state=RST, HOLD counter=0.
REQ-026 SHALL, on reset asserted mid-RUN or mid-HOLD, abort immediately to the values in REQ-025 and restart the full HOLD_CYCLES stretch after release.

Structure
REQ-027 SHALL place the state encoding (RST/HOLD/RUN), DIV and HOLD_CYCLES defaults, and the cycle_count width in a shared package, cpu_clk_pkg.
REQ-028 SHALL put the HOLD counter and core_reset register in one sub-module, rst_stretch, with inputs clock, reset and slow_rise and outputs core_reset and done.

Verification
REQ-029 SHALL cover the reset stretch: DIV=4, HOLD_CYCLES=8, 20 ns clock, reset high for 2 cycles then low -> core_reset falls on the 8th slow falling edge after release; clocks_ready rises on the same edge.
REQ-030 SHALL cover the divider: in RUN, measure processor_clock -> period 80 ns, high 40 ns, regfile_clock identical, imem_clock and dmem_clock equal to ~clock at every sample.
REQ-031 SHALL cover clk_hold: assert clk_hold for 10 clock cycles mid-RUN with cycle_count=N -> processor_clock stays low with no pulse narrower than 40 ns; after release cycle_count continues from N with no lost or extra count.
REQ-032 SHALL cover reset mid-RUN: pulse reset at cycle_count=5, off-edge (e.g. 3 ns after a clock edge) -> outputs reach their reset values with no clock edge, and the full 8-cycle stretch repeats.
REQ-033 SHALL cover wrap-around: force cycle_count to 0xFFFFFFFE -> reads 0xFFFFFFFF, then 0x00000000 on the next two slow rising edges.
REQ-034 SHALL cover clk_hold during HOLD: assert clk_hold for 12 cycles in HOLD -> core_reset is released 12 fast cycles later than in the REQ-029 case.
